// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - segment patterns and BCD decode shared by the display driver
package clock_disp_pkg;

    // Patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// rtl/seg7_scan_driver_decode.sv - combinational BCD to active-low segments
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with frame snapshot and ghost blanking
module seg7_scan_driver
    import clock_disp_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int NUM_DIGITS   = 6,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int SLOT   = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
    localparam int SLOT_W = (SLOT > 2) ? $clog2(SLOT) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [SLOT_W-1:0]       slot_cnt, slot_next;
    logic [IDX_W-1:0]        idx, idx_next;
    phase_t                  phase, phase_next;
    logic [4*NUM_DIGITS-1:0] snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic                    tick, wrap, lead_zero;
    logic [3:0]              cur_digit;
    logic [6:0]              dec_seg;

    always_comb begin
        tick       = (slot_cnt == SLOT_W'(SLOT - 1));
        wrap       = tick && (idx == IDX_W'(NUM_DIGITS - 1));
        slot_next  = tick ? '0 : slot_cnt + 1'b1;
        idx_next   = idx;
        if (tick) begin
            idx_next = wrap ? '0 : idx + 1'b1;
        end
        phase_next = phase;
        if (tick) begin
            phase_next = PH_BLANK;
        end else if (phase == PH_BLANK && slot_next == SLOT_W'(BLANK_CYCLES)) begin
            phase_next = PH_SHOW;
        end
    end

    // SHOW never begins on a tick, so idx and snap already hold the slot's values here.
    always_comb begin
        cur_digit = snap[4*idx +: 4];
        lead_zero = blank_lz && (idx == IDX_W'(NUM_DIGITS - 1)) && (cur_digit == 4'd0);
    end

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            idx         <= '0;
            phase       <= PH_BLANK;
            snap        <= '0;
            dp_snap     <= '0;
            frame_start <= 1'b0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            slot_cnt    <= slot_next;
            idx         <= idx_next;
            phase       <= phase_next;
            frame_start <= wrap;
            if (wrap) begin
                snap    <= digit_in;
                dp_snap <= dp_mask;
            end
            if (phase_next == PH_SHOW) begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= lead_zero ? SEG_OFF : dec_seg;
                dp  <= ~dp_snap[idx];
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int ND   = 6;
    localparam int SLOT = 4;
    localparam int FRM  = ND * SLOT;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   digit_in;
    logic [5:0]    dp_mask;
    logic          blank_lz;
    logic [5:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    logic [5:0] cap_an  [ND];
    logic [6:0] cap_seg [ND];
    logic       cap_dp  [ND];
    logic [5:0] cyc_an  [FRM];
    logic       fs_after;

    seg7_scan_driver #(
        .CLK_HZ       (48),
        .SCAN_HZ      (2),
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_in    (digit_in),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Wait for frame_start, then record one full frame; slot k is sampled mid-slot at offset 4k+2.
    task automatic capture_frame(input int chg_off, input logic [23:0] chg_val);
        int n;
        bit got;
        got = 1'b0;
        for (n = 0; n < 4 * FRM; n++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL frame_start_timeout: saw no pulse in %0d cycles, required one", 4 * FRM);
        end
        for (int off = 0; off < FRM; off++) begin
            if (off > 0) @(negedge clk);
            cyc_an[off] = an;
            if (off == 1) fs_after = frame_start;
            if (off % SLOT == 2) begin
                cap_an[off / SLOT]  = an;
                cap_seg[off / SLOT] = seg;
                cap_dp[off / SLOT]  = dp;
            end
            if (off == chg_off) digit_in = chg_val;
        end
    endtask

    task automatic check_frame(input string name, input logic [6:0] exp_seg [ND]);
        logic [5:0] exp_an;
        for (int k = 0; k < ND; k++) begin
            exp_an = ~(6'd1 << k);
            checks++;
            if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg[k]) begin
                errors++;
                $display("FAIL %s digit%0d: an=%b seg=%b, required an=%b seg=%b",
                         name, k, cap_an[k], cap_seg[k], exp_an, exp_seg[k]);
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        digit_in = 24'h123459;
        dp_mask  = 6'b000000;
        blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: an=%b seg=%b dp=%b fs=%b, required 111111 1111111 1 0",
                         i, an, seg, dp, frame_start);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 6'b111110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL first_show: an=%b seg=%b, required an=111110 seg=1000000", an, seg);
        end
    endtask

    task automatic test_hold;
        logic [6:0] exp [ND];
        exp = '{7'b0010000, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        capture_frame(-1, 24'h0);
        capture_frame(-1, 24'h0);
        check_frame("hold_123459", exp);
        checks++;
        if (fs_after !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width: fs=%b one cycle after pulse, required 0", fs_after);
        end
    endtask

    task automatic test_mid_change;
        logic [6:0] exp_a [ND];
        logic [6:0] exp_b [ND];
        exp_a = '{7'b0010000, 7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        exp_b = '{7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000};
        digit_in = 24'h000059;
        capture_frame(3, 24'h000100);
        check_frame("pre_change", exp_a);
        capture_frame(-1, 24'h0);
        check_frame("post_change", exp_b);
    endtask

    task automatic test_leading_zero;
        digit_in = 24'h012345;
        blank_lz = 1'b1;
        capture_frame(-1, 24'h0);
        checks++;
        if (cap_an[5] !== 6'b011111 || cap_seg[5] !== 7'b1111111) begin
            errors++;
            $display("FAIL lz_blank: an=%b seg=%b, required an=011111 seg=1111111", cap_an[5], cap_seg[5]);
        end
        checks++;
        if (cap_seg[0] !== 7'b0010010) begin
            errors++;
            $display("FAIL lz_digit0: seg=%b, required 0010010", cap_seg[0]);
        end
        blank_lz = 1'b0;
        capture_frame(-1, 24'h0);
        checks++;
        if (cap_an[5] !== 6'b011111 || cap_seg[5] !== 7'b1000000) begin
            errors++;
            $display("FAIL lz_off: an=%b seg=%b, required an=011111 seg=1000000", cap_an[5], cap_seg[5]);
        end
    endtask

    task automatic test_dash;
        digit_in = 24'h00000C;
        capture_frame(-1, 24'h0);
        checks++;
        if (cap_an[0] !== 6'b111110 || cap_seg[0] !== 7'b0111111) begin
            errors++;
            $display("FAIL dash: an=%b seg=%b, required an=111110 seg=0111111", cap_an[0], cap_seg[0]);
        end
    endtask

    task automatic test_dp_and_blanking;
        logic [5:0] exp_an;
        logic       exp_dp;
        dp_mask  = 6'b010100;
        digit_in = 24'h000000;
        capture_frame(-1, 24'h0);
        for (int k = 0; k < ND; k++) begin
            exp_dp = !(k == 2 || k == 4);
            checks++;
            if (cap_dp[k] !== exp_dp) begin
                errors++;
                $display("FAIL dp_slot%0d: dp=%b, required %b", k, cap_dp[k], exp_dp);
            end
        end
        for (int off = 0; off < FRM; off++) begin
            exp_an = (off % SLOT == 0) ? 6'b111111 : ~(6'd1 << (off / SLOT));
            checks++;
            if (cyc_an[off] !== exp_an) begin
                errors++;
                $display("FAIL blank_gap off%0d: an=%b, required %b", off, cyc_an[off], exp_an);
            end
        end
    endtask

    task automatic test_reset_mid_slot;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL midslot_reset: an=%b seg=%b dp=%b fs=%b, required 111111 1111111 1 0",
                     an, seg, dp, frame_start);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 6'b111110 || seg !== 7'b1000000 || dp !== 1'b1) begin
            errors++;
            $display("FAIL restart_idx0: an=%b seg=%b dp=%b, required an=111110 seg=1000000 dp=1", an, seg, dp);
        end
    endtask

    initial begin
        test_reset;
        test_hold;
        test_mid_change;
        test_leading_zero;
        test_dash;
        test_dp_and_blanking;
        test_reset_mid_slot;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
